alu_exec: RTL and testbench

Execute-stage ALU consuming the 4-bit ALU control code from the ALU control decoder plus two operand buses, and producing a registered result, zero and overflow flags. Every operation except MULA completes in one cycle; MULA runs a WIDTH-cycle shift-add multiplier. Valid/ready handshakes on both sides let the block stall the pipeline during multiplies and absorb back-pressure from the memory/writeback stage.

---
 rtl/alu_defs_pkg.sv | 19 +
 rtl/alu_mul_seq.sv | 39 +++
 rtl/alu_exec.sv | 96 +++++++++
 tb/tb_alu_exec.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
// alu_defs: operation codes shared with the ALU control decoder, plus execute-stage state encoding
package alu_defs;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_MULA = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_ADDU = 4'b1000;
  localparam logic [3:0] OP_SUBU = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_LUI  = 4'b1110;
  typedef enum logic {IDLE, MUL} state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: WIDTH-iteration shift-add multiplier, product valid combinationally while done is high
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] a_sh, b_sh, acc;
  logic [CW-1:0] cnt;
  assign product = acc + (b_sh[0] ? a_sh : '0);
  assign done = busy && cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      a_sh <= a;
      b_sh <= b;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc  <= product;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + 1'b1;
      busy <= !done;
    end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with valid/ready handshakes and a sequential multiply
module alu_exec
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] bus_a,
  input  logic [WIDTH-1:0] bus_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);
  state_t state, state_nx;
  logic [WIDTH-1:0] sum, dif, res_c, product;
  logic ovf_c, ill_c, fire, is_mul, start, busy, done;
  logic [4:0] sh;
  assign in_ready = state == IDLE && (!out_valid || out_ready);
  assign fire = in_valid && in_ready;
  assign is_mul = alu_ctrl == OP_MULA;
  assign start = fire && is_mul;
  assign sum = bus_a + bus_b;
  assign dif = bus_a - bus_b;
  assign sh = bus_a[4:0];
  assign state_nx = start ? MUL : (state == MUL && busy && !done) ? MUL : IDLE;
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    ill_c = 1'b0;
    case (alu_ctrl)
      OP_AND:  res_c = bus_a & bus_b;
      OP_OR:   res_c = bus_a | bus_b;
      OP_ADD: begin
        res_c = sum;
        ovf_c = bus_a[WIDTH-1] == bus_b[WIDTH-1] && sum[WIDTH-1] != bus_a[WIDTH-1];
      end
      OP_SLL:  res_c = bus_b << sh;
      OP_SRL:  res_c = bus_b >> sh;
      OP_MULA: res_c = '0;
      OP_SUB: begin
        res_c = dif;
        ovf_c = bus_a[WIDTH-1] != bus_b[WIDTH-1] && dif[WIDTH-1] != bus_a[WIDTH-1];
      end
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, $signed(bus_a) < $signed(bus_b)};
      OP_ADDU: res_c = sum;
      OP_SUBU: res_c = dif;
      OP_XOR:  res_c = bus_a ^ bus_b;
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, bus_a < bus_b};
      OP_NOR:  res_c = ~(bus_a | bus_b);
      OP_SRA:  res_c = $signed(bus_b) >>> sh;
      OP_LUI:  res_c = {bus_b[15:0], {(WIDTH-16){1'b0}}};
      default: ill_c = 1'b1;
    endcase
  end
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (bus_a),
    .b       (bus_b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state <= state_nx;
      if (done) begin
        out_valid <= 1'b1;
        result    <= product;
        zero      <= product == '0;
        overflow  <= 1'b0;
        illegal   <= 1'b0;
      end else if (fire && !is_mul) begin
        out_valid <= 1'b1;
        result    <= res_c;
        zero      <= res_c == '0;
        overflow  <= ovf_c;
        illegal   <= ill_c;
      end else if (start || out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec with directed vectors
module tb_alu_exec;
  import alu_defs::*;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic zero, overflow, illegal;
  logic [3:0] alu_ctrl = 0;
  logic [31:0] bus_a = 0, bus_b = 0, result;
  typedef struct {string nm; logic [31:0] r; logic o; logic il;} exp_t;
  exp_t exp_q[$];
  int cmp = 0, bad = 0;

  alu_exec #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .bus_a(bus_a), .bus_b(bus_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .overflow(overflow),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      cmp++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got result=%h with no pending expectation", result);
      end else begin
        e = exp_q.pop_front();
        if (result !== e.r || zero !== (e.r == 0) || overflow !== e.o || illegal !== e.il) begin
          bad++;
          $display("FAIL %s: got r=%h z=%b o=%b il=%b expected r=%h z=%b o=%b il=%b",
                   e.nm, result, zero, overflow, illegal, e.r, e.r == 0, e.o, e.il);
        end
      end
    end

  task automatic issue(input string nm, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic o, input logic il);
    int n = 0;
    @(posedge clk); #1;
    alu_ctrl = c; bus_a = a; bus_b = b; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      cmp++; bad++;
      $display("FAIL %s_accept: in_ready stayed 0 expected 1", nm);
      in_valid = 0;
      return;
    end
    exp_q.push_back('{nm, r, o, il});
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic mula_timed(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    int lat = 0;
    int busy_bad = 0;
    issue(nm, OP_MULA, a, b, r, 0, 0);
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_bad++;
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, 32);
    check({nm, "_in_ready_low"}, busy_bad, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 0);
    check("reset_result", result, 0);
    check("reset_flags", {29'b0, zero, overflow, illegal}, 0);
    rst_n = 1;
    #1 check("reset_in_ready", {31'b0, in_ready}, 1);

    issue("mula_abort", OP_MULA, 32'h1234_5678, 32'h10, 32'h2345_6780, 0, 0);
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    exp_q.delete();
    #1;
    check("midmul_rst_out_valid", {31'b0, out_valid}, 0);
    check("midmul_rst_result", result, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("midmul_rst_in_ready", {31'b0, in_ready}, 1);
    issue("add_2_3", OP_ADD, 2, 3, 5, 0, 0);

    issue("add_ovf", OP_ADD, 32'h7FFF_FFFF, 1, 32'h8000_0000, 1, 0);
    issue("addu_noovf", OP_ADDU, 32'h7FFF_FFFF, 1, 32'h8000_0000, 0, 0);
    issue("sub_zero", OP_SUB, 5, 5, 0, 0, 0);
    issue("sub_ovf", OP_SUB, 32'h8000_0000, 1, 32'h7FFF_FFFF, 1, 0);
    issue("sll", OP_SLL, 4, 32'h8000_0010, 32'h0000_0100, 0, 0);
    issue("srl", OP_SRL, 4, 32'h8000_0010, 32'h0800_0001, 0, 0);
    issue("sra", OP_SRA, 4, 32'h8000_0010, 32'hF800_0001, 0, 0);
    issue("lui", OP_LUI, 0, 32'h1234, 32'h1234_0000, 0, 0);
    issue("slt", OP_SLT, 32'hFFFF_FFFF, 1, 1, 0, 0);
    issue("sltu", OP_SLTU, 32'hFFFF_FFFF, 1, 0, 0, 0);
    issue("xor", OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 0, 0);
    issue("nor", OP_NOR, 32'hFF00_0000, 32'h0000_00FF, 32'h00FF_FF00, 0, 0);
    issue("subu", OP_SUBU, 0, 1, 32'hFFFF_FFFF, 0, 0);
    issue("illegal_1111", 4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0, 1);

    mula_timed("mula_shift", 32'h1234_5678, 32'h10, 32'h2345_6780);
    mula_timed("mula_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);

    @(posedge clk); #1 out_ready = 0;
    issue("bp_and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0, 0);
    alu_ctrl = OP_OR; bus_a = 32'hF0F0_1234; bus_b = 32'h0FF0_FF00; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", {31'b0, in_ready}, 0);
      check("bp_result_hold", result, 32'h00F0_1200);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(negedge clk);
    check("bp_release_in_ready", {30'b0, in_ready, out_valid}, 3);
    exp_q.push_back('{"bp_or", 32'hFFF0_FF34, 1'b0, 1'b0});
    @(posedge clk); #1 in_valid = 0;
    check("bp_or_loaded", {out_valid, result[30:0]}, {1'b1, 31'h7FF0_FF34});

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
